// File: rtl/fetch_pkg.sv
// Shared types and instruction encodings for the instruction fetch controller,
// its prefetch queue and the instruction memory model.
package fetch_pkg;

  localparam int PC_W = 30;

  localparam logic [31:0] SYSCALL_INST      = 32'h0000_000C;
  localparam logic [31:0] SYSCALL_SUBS_INST = 32'h0082_0020;
  localparam logic [31:0] NOP_INST          = 32'h0000_0000;

  typedef enum logic {
    FETCH,
    SYS_WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     raw;
    logic [31:0]     instr;
    logic            is_syscall;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry circular prefetch FIFO of fetch entries with push, pop and flush.
// Head outputs read zero whenever the queue is empty.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic         full,
  output logic         empty
);

  fetch_entry_t slots [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only visible through
  // count, so stale contents can never leak out.
  always_ff @(posedge clk) begin
    if (push && !flush) slots[wr_ptr] <= wr_entry;
  end

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign rd_entry = empty ? '0 : slots[rd_ptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: holds each word address for WAIT_CYCLES, captures
// the word into the prefetch queue with syscall/unknown substitution.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                ADDR_W            = fetch_pkg::PC_W,
  parameter int                WAIT_CYCLES       = 2,
  parameter logic [ADDR_W-1:0] RESET_PC          = 'h0010_0000,
  parameter logic [31:0]       SYSCALL_INST      = fetch_pkg::SYSCALL_INST,
  parameter logic [31:0]       SYSCALL_SUBS_INST = fetch_pkg::SYSCALL_SUBS_INST,
  parameter logic [31:0]       NOP_INST          = fetch_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              syscall_done,
  input  logic              dec_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_raw,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_is_syscall,
  output logic              fetch_stalled
);

  localparam logic [2:0] WAIT_RELOAD = 3'(WAIT_CYCLES);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [2:0]        wait_cnt, wait_cnt_nxt;
  logic              push, pop, flush;
  logic              q_full, q_empty;
  logic              raw_unknown;
  fetch_entry_t      cap_entry;
  fetch_entry_t      head;

  // Any X/Z bit models a read of unpopulated memory; synthesis folds this to 0.
  assign raw_unknown = ((^mem_data) === 1'bx);
  assign pop         = !q_empty && dec_ready;

  always_comb begin
    cap_entry.pc         = fetch_pc;
    cap_entry.raw        = mem_data;
    cap_entry.is_syscall = !raw_unknown && (mem_data == SYSCALL_INST);
    if (raw_unknown)               cap_entry.instr = NOP_INST;
    else if (cap_entry.is_syscall) cap_entry.instr = SYSCALL_SUBS_INST;
    else                           cap_entry.instr = mem_data;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    wait_cnt_nxt = wait_cnt;
    push         = 1'b0;
    flush        = 1'b0;
    if (redirect_valid) begin
      // Redirect overrides everything, including a capture due this edge.
      flush        = 1'b1;
      fetch_pc_nxt = redirect_addr;
      wait_cnt_nxt = WAIT_RELOAD;
      state_nxt    = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt_nxt = wait_cnt - 3'd1;
          end else if (!q_full || pop) begin
            push         = 1'b1;
            fetch_pc_nxt = fetch_pc + ADDR_W'(1);
            wait_cnt_nxt = WAIT_RELOAD;
            if (cap_entry.is_syscall) state_nxt = SYS_WAIT;
          end
        end
        SYS_WAIT: begin
          if (syscall_done) begin
            state_nxt    = FETCH;
            wait_cnt_nxt = WAIT_RELOAD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      wait_cnt <= WAIT_RELOAD;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  fetch_queue u_queue (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (cap_entry),
    .rd_entry (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  assign mem_addr         = fetch_pc;
  assign instr_valid      = !q_empty;
  assign instr            = head.instr;
  assign instr_raw        = head.raw;
  assign instr_pc         = head.pc;
  assign instr_is_syscall = head.is_syscall;
  assign fetch_stalled    = (state == SYS_WAIT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: memory model, scoreboard of popped
// entries, and directed checks of latency, backpressure, redirect, syscall, reset.
module tb_imem_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [29:0] RESET_PC = 30'h0010_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [29:0] redirect_addr;
  logic        syscall_done;
  logic        dec_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_raw;
  logic [29:0] instr_pc;
  logic        instr_is_syscall;
  logic        fetch_stalled;

  logic [31:0]  x_word;
  int           errors = 0;
  int           checks = 0;
  fetch_entry_t exp_q[$];

  imem_fetch_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .syscall_done     (syscall_done),
    .dec_ready        (dec_ready),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_raw        (instr_raw),
    .instr_pc         (instr_pc),
    .instr_is_syscall (instr_is_syscall),
    .fetch_stalled    (fetch_stalled)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    case (a)
      30'h0010_0000: return 32'h2001_0001;
      30'h0010_0001: return 32'h2002_0002;
      30'h0010_0002: return 32'h2003_0003;
      30'h0010_0003: return 32'h0000_000C;
      30'h0010_0004: return 32'h2005_0005;
      30'h0010_0005: return 32'h2006_0006;
      30'h0010_0040: return 32'h2040_0040;
      30'h0010_0041: return 32'h2041_0041;
      default:       return x_word;
    endcase
  endfunction

  always_comb mem_data = mem_word(mem_addr);

  function automatic fetch_entry_t exp_entry(input logic [29:0] a);
    fetch_entry_t e;
    logic [31:0]  w;
    w            = mem_word(a);
    e.pc         = a;
    e.raw        = w;
    e.is_syscall = (w === SYSCALL_INST);
    if ($isunknown(w))     e.instr = NOP_INST;
    else if (e.is_syscall) e.instr = SYSCALL_SUBS_INST;
    else                   e.instr = w;
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (instr_valid) begin
        n = i;
        break;
      end
    end
  endtask

  // Scoreboard: every pop must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && instr_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pop", 128'(exp_q.size()), 128'(1));
      end else begin
        fetch_entry_t got_e, want_e;
        want_e = exp_q.pop_front();
        got_e  = '{pc: instr_pc, raw: instr_raw, instr: instr, is_syscall: instr_is_syscall};
        check("sb_entry", 128'(got_e), 128'(want_e));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int changes;
    logic [29:0] prev;
    bit found;

    x_word         = 'x;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    syscall_done   = 1'b0;
    dec_ready      = 1'b1;
    repeat (3) tick();

    check("rst_mem_addr", 128'(mem_addr), 128'(RESET_PC));
    check("rst_valid", 128'(instr_valid), 128'(0));
    check("rst_instr", 128'(instr), 128'(0));
    check("rst_raw", 128'(instr_raw), 128'(0));
    check("rst_pc", 128'(instr_pc), 128'(0));
    check("rst_sys", 128'(instr_is_syscall), 128'(0));
    check("rst_stalled", 128'(fetch_stalled), 128'(0));

    // First fetches after reset release.
    exp_q.push_back(exp_entry(30'h0010_0000));
    exp_q.push_back(exp_entry(30'h0010_0001));
    reset_n = 1'b1;
    wait_valid(n);
    check("first_latency", 128'(n), 128'(3));
    check("first_pc", 128'(instr_pc), 128'(30'h0010_0000));
    wait_valid(n);
    check("second_latency", 128'(n), 128'(3));
    check("second_pc", 128'(instr_pc), 128'(30'h0010_0001));

    // Redirect with one queued entry, wait_cnt=1.
    tick();
    wait_valid(n);
    dec_ready = 1'b0;
    check("pre_redir_pc", 128'(instr_pc), 128'(30'h0010_0002));
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 30'h0010_0040;
    tick();
    redirect_valid = 1'b0;
    check("redir_flush", 128'(instr_valid), 128'(0));
    check("redir_addr", 128'(mem_addr), 128'(30'h0010_0040));
    exp_q.push_back(exp_entry(30'h0010_0040));
    dec_ready = 1'b1;
    wait_valid(n);
    check("redir_latency", 128'(n), 128'(3));
    check("redir_pc", 128'(instr_pc), 128'(30'h0010_0040));

    // Backpressure: restart at RESET_PC with decode stalled.
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 30'h0010_0000;
    dec_ready      = 1'b0;
    tick();
    redirect_valid = 1'b0;
    changes = 0;
    for (int i = 0; i < 12; i++) begin
      prev = mem_addr;
      tick();
      if (mem_addr != prev) changes++;
    end
    check("bp_captures", 128'(changes), 128'(2));
    check("bp_addr_held", 128'(mem_addr), 128'(30'h0010_0002));
    check("bp_head_pc", 128'(instr_pc), 128'(30'h0010_0000));

    for (int a = 0; a < 4; a++) exp_q.push_back(exp_entry(30'h0010_0000 + 30'(a)));
    dec_ready = 1'b1;

    // Syscall capture and stall.
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instr_valid && instr_is_syscall) begin
        found = 1'b1;
        break;
      end
    end
    check("sys_seen", 128'(found), 128'(1));
    check("sys_instr", 128'(instr), 128'(32'h0082_0020));
    check("sys_raw", 128'(instr_raw), 128'(32'h0000_000C));
    check("sys_pc", 128'(instr_pc), 128'(30'h0010_0003));
    check("sys_stalled", 128'(fetch_stalled), 128'(1));
    check("sys_addr", 128'(mem_addr), 128'(30'h0010_0004));
    repeat (5) tick();
    check("sys_hold_stalled", 128'(fetch_stalled), 128'(1));
    check("sys_hold_addr", 128'(mem_addr), 128'(30'h0010_0004));
    check("sys_drained", 128'(instr_valid), 128'(0));

    exp_q.push_back(exp_entry(30'h0010_0004));
    syscall_done = 1'b1;
    tick();
    syscall_done = 1'b0;
    check("sys_released", 128'(fetch_stalled), 128'(0));
    wait_valid(n);
    check("sys_resume_latency", 128'(n), 128'(3));
    check("sys_resume_pc", 128'(instr_pc), 128'(30'h0010_0004));

    // Unpopulated address returns unknown data.
    redirect_valid = 1'b1;
    redirect_addr  = 30'h0020_0000;
    tick();
    redirect_valid = 1'b0;
    exp_q.push_back(exp_entry(30'h0020_0000));
    wait_valid(n);
    check("unk_latency", 128'(n), 128'(3));
    check("unk_instr", 128'(instr), 128'(exp_entry(30'h0020_0000).instr));
    check("unk_raw", 128'(instr_raw), 128'(x_word));

    // Asynchronous reset mid-wait with a full queue.
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 30'h0010_0000;
    dec_ready      = 1'b0;
    tick();
    redirect_valid = 1'b0;
    repeat (7) tick();
    check("full_before_rst", 128'(instr_valid), 128'(1));
    check("full_addr", 128'(mem_addr), 128'(30'h0010_0002));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", 128'(instr_valid), 128'(0));
    check("async_instr", 128'(instr), 128'(0));
    check("async_pc", 128'(instr_pc), 128'(0));
    check("async_addr", 128'(mem_addr), 128'(RESET_PC));
    repeat (2) tick();
    exp_q.push_back(exp_entry(30'h0010_0000));
    dec_ready = 1'b1;
    reset_n   = 1'b1;
    wait_valid(n);
    check("restart_latency", 128'(n), 128'(3));
    check("restart_pc", 128'(instr_pc), 128'(30'h0010_0000));
    tick();
    check("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
